// File: rtl/chess_clock_core_if.sv
// Turn-clock bus: player buttons and control pulses in,
// turn/flag markers, readout and buzzer out.
interface chess_clock_core_if #(
    parameter int N_PLAYERS = 2,
    parameter int TIME_W    = 9,
    parameter int SEL_W     = 1
);
    logic [N_PLAYERS-1:0] btn;
    logic                 start;
    logic                 pause;
    logic [SEL_W-1:0]     rd_sel;
    logic [N_PLAYERS-1:0] active;
    logic [TIME_W-1:0]    rd_time;
    logic                 running;
    logic                 warn;
    logic [N_PLAYERS-1:0] flagged;
    logic                 buzz_en;

    modport master (
        output btn, start, pause, rd_sel,
        input  active, rd_time, running,
        input  warn, flagged, buzz_en
    );

    modport slave (
        input  btn, start, pause, rd_sel,
        output active, rd_time, running,
        output warn, flagged, buzz_en
    );
endinterface

// File: rtl/chess_clock_core.sv
// N-player chess clock: per-player countdown, Fischer increment,
// low-time warning, flag detection and a bounded buzzer window.
module chess_clock_core #(
    parameter int N_PLAYERS = 2,
    parameter int TIME_W    = 9,
    parameter int INIT_TIME = 300,
    parameter int INCREMENT = 0,
    parameter int TICK_DIV  = 10,
    parameter int WARN_TIME = 30,
    parameter int BUZZ_LEN  = 20,
    parameter int SEL_W     =
        (N_PLAYERS > 2) ? $clog2(N_PLAYERS) : 1
) (
    input logic clk,
    input logic rst,
    chess_clock_core_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE, RUN, PAUSE, OVER
    } state_t;

    localparam int IW = $clog2(N_PLAYERS);
    localparam int PW = $clog2(TICK_DIV);
    localparam int BW = $clog2(BUZZ_LEN + 1);
    localparam logic [TIME_W-1:0] T_INIT =
        TIME_W'(INIT_TIME);
    localparam logic [TIME_W-1:0] T_MAX = '1;

    state_t               state;
    logic [TIME_W-1:0]    tm [N_PLAYERS];
    logic [IW-1:0]        idx;
    logic [PW-1:0]        presc;
    logic [BW-1:0]        bcnt;
    logic [N_PLAYERS-1:0] flg;
    logic [N_PLAYERS-1:0] btn_q;
    logic [TIME_W-1:0]    rd_q;

    logic                 wrap;
    logic                 hit;
    logic                 flag;
    logic                 init;
    logic [N_PLAYERS-1:0] rise;
    logic [TIME_W-1:0]    t_act;
    logic [TIME_W-1:0]    t_dec;
    logic [TIME_W-1:0]    t_inc;
    logic [31:0]          sum;
    logic [IW-1:0]        nxt_idx;
    logic [TIME_W-1:0]    rd_nxt;

    always_comb begin
        wrap    = presc == PW'(TICK_DIV - 1);
        rise    = bus.btn & ~btn_q;
        hit     = rise[idx];
        t_act   = tm[idx];
        flag    = wrap && (t_act == TIME_W'(1));
        t_dec   = t_act - TIME_W'(wrap);
        sum     = 32'(t_dec) + 32'(INCREMENT);
        t_inc   = (sum > 32'(T_MAX)) ? T_MAX
                                     : sum[TIME_W-1:0];
        nxt_idx = (idx == IW'(N_PLAYERS - 1))
                  ? '0 : idx + IW'(1);
        init    = rst || (state == OVER && bus.start);
    end

    // Out-of-range selects read back as zero.
    always_comb begin
        rd_nxt = '0;
        for (int i = 0; i < N_PLAYERS; i++)
            if (bus.rd_sel == SEL_W'(i))
                rd_nxt = tm[i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_q <= '0;
            rd_q  <= '0;
        end else begin
            btn_q <= bus.btn;
            rd_q  <= rd_nxt;
        end

        if (init) begin
            state <= IDLE;
            for (int i = 0; i < N_PLAYERS; i++)
                tm[i] <= T_INIT;
            idx   <= '0;
            presc <= '0;
            bcnt  <= '0;
            flg   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        state <= RUN;
                        presc <= '0;
                    end
                end
                RUN: begin
                    // Flag wins over a press; a press wins over pause.
                    if (flag) begin
                        tm[idx] <= '0;
                        flg     <= N_PLAYERS'(1) << idx;
                        bcnt    <= BW'(BUZZ_LEN);
                        presc   <= '0;
                        state   <= OVER;
                    end else if (hit) begin
                        tm[idx] <= t_inc;
                        idx     <= nxt_idx;
                        presc   <= '0;
                    end else if (bus.pause) begin
                        state <= PAUSE;
                    end else begin
                        presc <= wrap ? '0 : presc + PW'(1);
                        if (wrap)
                            tm[idx] <= t_dec;
                    end
                end
                PAUSE: begin
                    if (bus.pause)
                        state <= RUN;
                end
                OVER: begin
                    presc <= wrap ? '0 : presc + PW'(1);
                    if (wrap && bcnt != '0)
                        bcnt <= bcnt - BW'(1);
                end
            endcase
        end
    end

    assign bus.active  = N_PLAYERS'(1) << idx;
    assign bus.rd_time = rd_q;
    assign bus.running = state == RUN;
    assign bus.warn    = (state == RUN) &&
                         (32'(t_act) <= 32'(WARN_TIME));
    assign bus.flagged = flg;
    assign bus.buzz_en = bcnt != '0;
endmodule

// File: tb/tb_chess_clock_core.sv
// Bench for chess_clock_core: two parameter sets driven from
// vector tables through a scoreboard queue, plus a flag/buzz run.
module tb_chess_clock_core;
    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;

    always #5 clk = ~clk;

    chess_clock_core_if #(
        .N_PLAYERS(2), .TIME_W(9), .SEL_W(1)
    ) ifa ();

    chess_clock_core_if #(
        .N_PLAYERS(3), .TIME_W(4), .SEL_W(2)
    ) ifb ();

    chess_clock_core #(
        .N_PLAYERS(2), .TIME_W(9), .INIT_TIME(5),
        .INCREMENT(3), .TICK_DIV(4), .WARN_TIME(3),
        .BUZZ_LEN(2), .SEL_W(1)
    ) dut_a (
        .clk(clk), .rst(rst_a), .bus(ifa)
    );

    chess_clock_core #(
        .N_PLAYERS(3), .TIME_W(4), .INIT_TIME(14),
        .INCREMENT(5), .TICK_DIV(4), .WARN_TIME(2),
        .BUZZ_LEN(1), .SEL_W(2)
    ) dut_b (
        .clk(clk), .rst(rst_b), .bus(ifb)
    );

    typedef struct {
        logic        rst;
        logic        start;
        logic        pause;
        logic [7:0]  btn;
        logic [2:0]  sel;
        int          n;
        logic [7:0]  act;
        logic [15:0] rt;
        logic        run;
        logic        warn;
        logic [7:0]  flg;
        logic        buzz;
    } vec_t;

    typedef struct {
        int          row;
        logic [7:0]  act;
        logic [15:0] rt;
        logic        run;
        logic        warn;
        logic [7:0]  flg;
        logic        buzz;
    } exp_t;

    vec_t va[$];
    vec_t vb[$];
    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t v(
        input logic r, input logic s, input logic p,
        input logic [7:0] b, input logic [2:0] sel,
        input int n, input logic [7:0] act,
        input logic [15:0] rt, input logic run,
        input logic warn, input logic [7:0] flg,
        input logic buzz
    );
        vec_t x;
        x.rst = r; x.start = s; x.pause = p;
        x.btn = b; x.sel = sel; x.n = n;
        x.act = act; x.rt = rt; x.run = run;
        x.warn = warn; x.flg = flg; x.buzz = buzz;
        return x;
    endfunction

    function automatic exp_t to_exp(
        input vec_t x, input int row
    );
        exp_t e;
        e.row = row; e.act = x.act; e.rt = x.rt;
        e.run = x.run; e.warn = x.warn;
        e.flg = x.flg; e.buzz = x.buzz;
        return e;
    endfunction

    task automatic chk(
        input string u, input int row, input string f,
        input logic [15:0] got, input logic [15:0] want
    );
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s row %0d %s: got %0h want %0h",
                     u, row, f, got, want);
        end
    endtask

    task automatic pop_exp(
        input string u, output exp_t e, output bit ok
    );
        ok = 1'b1;
        if (sbq.size() == 0) begin
            n_cmp++;
            n_bad++;
            ok = 1'b0;
            $display("FAIL %s scoreboard: got empty want entry",
                     u);
        end else begin
            e = sbq.pop_front();
        end
    endtask

    task automatic apply_a(input vec_t x, input int row);
        exp_t e;
        bit   ok;
        @(negedge clk);
        rst_a      = x.rst;
        ifa.start  = x.start;
        ifa.pause  = x.pause;
        ifa.btn    = x.btn[1:0];
        ifa.rd_sel = x.sel[0:0];
        sbq.push_back(to_exp(x, row));
        repeat (x.n) @(posedge clk);
        #1;
        pop_exp("A", e, ok);
        if (ok) begin
            chk("A", e.row, "active", 16'(ifa.active), 16'(e.act));
            chk("A", e.row, "rd_time", 16'(ifa.rd_time), e.rt);
            chk("A", e.row, "running", 16'(ifa.running), 16'(e.run));
            chk("A", e.row, "warn", 16'(ifa.warn), 16'(e.warn));
            chk("A", e.row, "flagged", 16'(ifa.flagged), 16'(e.flg));
            chk("A", e.row, "buzz_en", 16'(ifa.buzz_en), 16'(e.buzz));
        end
    endtask

    task automatic apply_b(input vec_t x, input int row);
        exp_t e;
        bit   ok;
        @(negedge clk);
        rst_b      = x.rst;
        ifb.start  = x.start;
        ifb.pause  = x.pause;
        ifb.btn    = x.btn[2:0];
        ifb.rd_sel = x.sel[1:0];
        sbq.push_back(to_exp(x, row));
        repeat (x.n) @(posedge clk);
        #1;
        pop_exp("B", e, ok);
        if (ok) begin
            chk("B", e.row, "active", 16'(ifb.active), 16'(e.act));
            chk("B", e.row, "rd_time", 16'(ifb.rd_time), e.rt);
            chk("B", e.row, "running", 16'(ifb.running), 16'(e.run));
            chk("B", e.row, "warn", 16'(ifb.warn), 16'(e.warn));
            chk("B", e.row, "flagged", 16'(ifb.flagged), 16'(e.flg));
            chk("B", e.row, "buzz_en", 16'(ifb.buzz_en), 16'(e.buzz));
        end
    endtask

    initial begin
        int cyc;
        int nb;
        bit got;

        ifa.btn = '0; ifa.start = 0; ifa.pause = 0; ifa.rd_sel = '0;
        ifb.btn = '0; ifb.start = 0; ifb.pause = 0; ifb.rd_sel = '0;

        // r s p btn sel n | act rt run warn flg buzz
        va.push_back(v(1,0,0,0,0, 2, 1,0,0,0,0,0));
        va.push_back(v(0,0,0,0,0, 1, 1,5,0,0,0,0));
        va.push_back(v(0,0,0,1,0, 1, 1,5,0,0,0,0));
        va.push_back(v(0,0,1,0,0, 1, 1,5,0,0,0,0));
        va.push_back(v(0,1,0,0,0, 1, 1,5,1,0,0,0));
        va.push_back(v(0,0,0,0,0,12, 1,3,1,1,0,0));
        va.push_back(v(0,0,0,0,1, 1, 1,5,1,1,0,0));
        va.push_back(v(0,0,0,1,0, 1, 2,2,1,0,0,0));
        va.push_back(v(0,0,0,1,0, 1, 2,5,1,0,0,0));
        va.push_back(v(0,0,0,0,0, 1, 2,5,1,0,0,0));
        va.push_back(v(0,0,0,1,0, 1, 2,5,1,0,0,0));
        va.push_back(v(0,0,0,0,0, 1, 2,5,1,0,0,0));
        va.push_back(v(0,0,0,2,1,10, 1,7,1,1,0,0));
        va.push_back(v(0,0,1,0,0, 1, 1,3,0,0,0,0));
        va.push_back(v(0,0,0,1,0,20, 1,3,0,0,0,0));
        va.push_back(v(0,0,1,1,0, 1, 1,3,1,1,0,0));
        va.push_back(v(0,0,0,0,0, 2, 1,3,1,1,0,0));
        va.push_back(v(0,0,0,0,0, 1, 1,3,1,1,0,0));
        va.push_back(v(0,0,0,0,0, 1, 1,2,1,1,0,0));
        va.push_back(v(0,0,0,0,0, 6, 1,1,1,1,0,0));
        va.push_back(v(0,0,0,1,0, 1, 1,1,0,0,1,1));
        va.push_back(v(0,0,0,0,0, 1, 1,0,0,0,1,1));
        va.push_back(v(0,0,1,2,0, 1, 1,0,0,0,1,1));
        va.push_back(v(0,0,0,0,0, 5, 1,0,0,0,1,1));
        va.push_back(v(0,0,0,0,0, 1, 1,0,0,0,1,0));
        va.push_back(v(0,0,0,0,0, 5, 1,0,0,0,1,0));
        va.push_back(v(0,1,0,0,0, 1, 1,0,0,0,0,0));
        va.push_back(v(0,0,0,0,1, 1, 1,5,0,0,0,0));
        va.push_back(v(0,0,0,0,0, 1, 1,5,0,0,0,0));
        va.push_back(v(0,1,0,0,0, 1, 1,5,1,0,0,0));
        va.push_back(v(0,1,0,0,0, 1, 1,5,1,0,0,0));
        va.push_back(v(0,0,0,0,0, 3, 1,5,1,0,0,0));
        va.push_back(v(0,0,0,0,0, 1, 1,4,1,0,0,0));
        va.push_back(v(1,0,0,0,0, 1, 1,0,0,0,0,0));

        vb.push_back(v(1,0,0,0,0, 2, 1,0,0,0,0,0));
        vb.push_back(v(0,0,0,0,0, 1, 1,14,0,0,0,0));
        vb.push_back(v(0,1,0,0,3, 1, 1,0,1,0,0,0));
        vb.push_back(v(0,0,0,1,0, 1, 2,14,1,0,0,0));
        vb.push_back(v(0,0,0,0,0, 1, 2,15,1,0,0,0));
        vb.push_back(v(0,0,0,2,1, 1, 4,14,1,0,0,0));
        vb.push_back(v(0,0,0,0,1, 1, 4,15,1,0,0,0));
        vb.push_back(v(0,0,0,4,2, 1, 1,14,1,0,0,0));
        vb.push_back(v(0,0,0,0,2, 1, 1,15,1,0,0,0));
        vb.push_back(v(0,0,0,0,3, 1, 1,0,1,0,0,0));
        vb.push_back(v(1,0,0,0,0, 1, 1,0,0,0,0,0));
        vb.push_back(v(0,0,0,0,0, 1, 1,14,0,0,0,0));

        foreach (va[i]) apply_a(va[i], i);

        // Uninterrupted run from reset to flag, then the buzz window.
        @(negedge clk);
        rst_a = 1'b0;
        ifa.start = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        ifa.start = 1'b0;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (ifa.flagged != '0) got = 1'b1;
        end
        chk("A", -1, "flag_cycles", 16'(cyc), 16'd20);
        chk("A", -1, "flag_player", 16'(ifa.flagged), 16'd1);
        nb = ifa.buzz_en ? 1 : 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            nb += ifa.buzz_en ? 1 : 0;
        end
        chk("A", -1, "buzz_cycles", 16'(nb), 16'd8);

        foreach (vb[i]) apply_b(vb[i], i);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
